// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit direction counters plus a tagged BTB,
// looked up combinationally at fetch and trained from the resolved EX outcome.
// A misprediction raises a registered one-cycle flush with the corrected PC.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_cf_op,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispredict_count
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Mispredict counter increment that sticks at all-ones.
    function automatic logic [31:0] count_sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [1:0]       cnt_q    [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]    if_tag;
    logic [TAG_W-1:0]    ex_tag;
    logic                if_hit;
    logic                upd_p0;
    logic                mis_p0;
    logic                unused_pc_bits;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_BITS+2];
    // Instructions are word aligned, so the low PC bits carry no information.
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Stage p0: fetch lookup against pre-edge table contents (no bypass).
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_valid && if_hit && cnt_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;

    // An EX instruction in the flush cycle is wrong-path and is ignored.
    assign upd_p0 = ex_valid && ex_cf_op && !flush;
    assign mis_p0 = upd_p0 && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));

    // Direction counters and BTB valid bits train on every resolved branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
            valid_q <= '0;
        end else if (upd_p0) begin
            cnt_q[ex_idx] <= ctr_step(cnt_q[ex_idx], ex_taken);
            if (ex_taken) valid_q[ex_idx] <= 1'b1;
        end
    end

    // Tag and target are only written on taken outcomes; valid qualifies them.
    always_ff @(posedge clk) begin
        if (upd_p0 && ex_taken) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
        end
    end

    // Stage p1: registered flush, redirect PC and mispredict statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush            <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= '0;
        end else begin
            flush <= mis_p0;
            if (mis_p0) begin
                redirect_pc      <= ex_taken ? ex_target : ex_pc + PC_STEP;
                mispredict_count <= count_sat_inc(mispredict_count);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios plus randomized traffic
// checked against a behavioural table model.
module tb_branch_predictor;
    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_cf_op;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int unsigned m_cnt [64];
    bit          m_val [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    bit          m_flush;
    logic [31:0] m_redir;
    longint      m_count;

    branch_predictor #(.IDX_BITS(6), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_cf_op(ex_cf_op), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .mispredict_count(mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc / 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_cnt[i] = 1;
            m_val[i] = 0;
        end
        m_flush = 0;
        m_redir = 0;
        m_count = 0;
    endtask

    task automatic model_lookup(input bit v, input logic [31:0] pc,
                                output bit pt, output logic [31:0] ptgt);
        int i;
        i = idx_of(pc);
        pt = v && m_val[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
        ptgt = pt ? m_tgt[i] : pc + 32'd4;
    endtask

    // Advance the model by one rising edge using the inputs the DUT sampled.
    task automatic model_clock();
        bit upd, mis;
        int i;
        upd = ex_valid && ex_cf_op && !m_flush;
        mis = upd && ((ex_taken != ex_pred_taken) ||
                      (ex_taken && ex_target != ex_pred_target));
        i = idx_of(ex_pc);
        if (upd) begin
            if (ex_taken) begin
                if (m_cnt[i] < 3) m_cnt[i]++;
                m_val[i] = 1;
                m_tag[i] = tag_of(ex_pc);
                m_tgt[i] = ex_target;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
            end
        end
        m_flush = mis;
        if (mis) begin
            m_redir = ex_taken ? ex_target : ex_pc + 32'd4;
            if (m_count < 64'hFFFF_FFFF) m_count++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_ex(input bit v, input bit cf, input logic [31:0] pc,
                          input bit tk, input logic [31:0] tgt,
                          input bit pt, input logic [31:0] ptgt);
        ex_valid = v; ex_cf_op = cf; ex_pc = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic ex_idle();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] exp_t;
        rst = 1; ex_idle(); if_valid = 1; if_pc = 32'h100;
        repeat (2) @(negedge clk);
        model_reset();
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0 || mispredict_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state flush=%b redirect=%h count=%0d required 0/0/0",
                     flush, redirect_pc, mispredict_count);
        end
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            if_pc = (i == 0) ? 32'h100 : (i == 1) ? 32'hFFFF_FFFC : $urandom;
            exp_t = if_pc + 32'd4;
            #1;
            n_checks++;
            if (pred_taken !== 1'b0 || pred_target !== exp_t) begin
                n_fail++;
                $display("FAIL reset_lookup pc=%h got %b/%h required 0/%h",
                         if_pc, pred_taken, pred_target, exp_t);
            end
            tick();
            @(negedge clk);
        end
    endtask

    task automatic test_first_branch();
        if_pc = 32'h100;
        set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        tick();
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h80 || mispredict_count !== 32'd1) begin
            n_fail++;
            $display("FAIL first_mispredict flush=%b redirect=%h count=%0d required 1/00000080/1",
                     flush, redirect_pc, mispredict_count);
        end
        @(negedge clk); ex_idle(); tick();
        n_checks++;
        if (flush !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_one_cycle flush=%b required 0", flush);
        end
        @(negedge clk); #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL trained_lookup got %b/%h required 1/00000080", pred_taken, pred_target);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            set_ex(1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
            tick();
            n_checks++;
            if (flush !== 1'b0) begin
                n_fail++;
                $display("FAIL correct_pred_flush iter=%0d flush=%b required 0", k, flush);
            end
            @(negedge clk);
        end
        set_ex(1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        tick();
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h104 || mispredict_count !== 32'd2) begin
            n_fail++;
            $display("FAIL not_taken_mispredict flush=%b redirect=%h count=%0d required 1/00000104/2",
                     flush, redirect_pc, mispredict_count);
        end
        @(negedge clk); ex_idle(); tick(); @(negedge clk);
        if_pc = 32'h100; #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL hysteresis_lookup got %b/%h required 1/00000080", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        if_pc = 32'h200; #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
            n_fail++;
            $display("FAIL alias_lookup got %b/%h required 0/00000204", pred_taken, pred_target);
        end
        if_valid = 0; if_pc = 32'h100; #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL if_invalid_lookup got %b/%h required 0/00000104", pred_taken, pred_target);
        end
        if_valid = 1;
        @(negedge clk);
    endtask

    task automatic test_wrong_target();
        set_ex(1, 1, 32'h100, 1, 32'h90, 1, 32'h80);
        tick();
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h90 || mispredict_count !== 32'd3) begin
            n_fail++;
            $display("FAIL wrong_target flush=%b redirect=%h count=%0d required 1/00000090/3",
                     flush, redirect_pc, mispredict_count);
        end
        @(negedge clk); ex_idle(); tick(); @(negedge clk);
        if_pc = 32'h100; #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
            n_fail++;
            $display("FAIL btb_target_update got %b/%h required 1/00000090", pred_taken, pred_target);
        end
    endtask

    task automatic test_non_cf();
        set_ex(1, 0, 32'h100, 0, 32'h0, 1, 32'h80);
        tick();
        n_checks++;
        if (flush !== 1'b0 || mispredict_count !== 32'd3) begin
            n_fail++;
            $display("FAIL non_cf_ignored flush=%b count=%0d required 0/3", flush, mispredict_count);
        end
        @(negedge clk);
        set_ex(0, 1, 32'h100, 0, 32'h0, 1, 32'h80);
        tick();
        @(negedge clk); ex_idle(); if_pc = 32'h100; #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
            n_fail++;
            $display("FAIL non_cf_table got %b/%h required 1/00000090", pred_taken, pred_target);
        end
    endtask

    task automatic test_back_to_back();
        set_ex(1, 1, 32'h140, 1, 32'hA0, 0, 32'h144);
        tick();
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'hA0 || mispredict_count !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_first flush=%b redirect=%h count=%0d required 1/000000a0/4",
                     flush, redirect_pc, mispredict_count);
        end
        @(negedge clk);
        set_ex(1, 1, 32'h144, 1, 32'hB0, 0, 32'h148);
        tick();
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'hA0 || mispredict_count !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_masked flush=%b redirect=%h count=%0d required 0/000000a0/4",
                     flush, redirect_pc, mispredict_count);
        end
        @(negedge clk); ex_idle(); if_pc = 32'h144; #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h148) begin
            n_fail++;
            $display("FAIL b2b_no_update got %b/%h required 0/00000148", pred_taken, pred_target);
        end
        if_pc = 32'h140; #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'hA0) begin
            n_fail++;
            $display("FAIL b2b_first_trained got %b/%h required 1/000000a0", pred_taken, pred_target);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit          ept;
        logic [31:0] etg;
        bit          xpt;
        logic [31:0] xtg;
        for (int n = 0; n < 400; n++) begin
            if_valid = ($urandom_range(0, 7) != 0);
            if_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            ex_valid = ($urandom_range(0, 4) != 0);
            ex_cf_op = ($urandom_range(0, 5) != 0);
            ex_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            ex_taken = $urandom_range(0, 1);
            ex_target = $urandom_range(0, 15) << 4;
            if ($urandom_range(0, 1) != 0) begin
                model_lookup(1'b1, ex_pc, xpt, xtg);
                ex_pred_taken = xpt; ex_pred_target = xtg;
            end else begin
                ex_pred_taken = $urandom_range(0, 1);
                ex_pred_target = $urandom_range(0, 15) << 4;
            end
            #1;
            model_lookup(if_valid, if_pc, ept, etg);
            n_checks++;
            if (pred_taken !== ept || pred_target !== etg) begin
                n_fail++;
                $display("FAIL rand_lookup n=%0d pc=%h got %b/%h required %b/%h",
                         n, if_pc, pred_taken, pred_target, ept, etg);
            end
            tick();
            n_checks++;
            if (flush !== m_flush || redirect_pc !== m_redir || mispredict_count !== m_count[31:0]) begin
                n_fail++;
                $display("FAIL rand_flush n=%0d got %b/%h/%0d required %b/%h/%0d",
                         n, flush, redirect_pc, mispredict_count, m_flush, m_redir, m_count);
            end
            @(negedge clk);
        end
        ex_idle(); if_valid = 1; tick(); @(negedge clk);
    endtask

    task automatic test_async_reset();
        set_ex(1, 1, 32'h240, 1, 32'h44, 0, 32'h0);
        tick();
        n_checks++;
        if (flush !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_flush flush=%b required 1", flush);
        end
        #2 rst = 1;
        #1;
        n_checks++;
        if (flush !== 1'b0 || mispredict_count !== 32'h0 || redirect_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset flush=%b count=%0d redirect=%h required 0/0/0",
                     flush, mispredict_count, redirect_pc);
        end
        model_reset();
        ex_idle();
        @(negedge clk); @(negedge clk);
        rst = 0; if_pc = 32'h100; #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL async_tables_cleared got %b/%h required 0/00000104", pred_taken, pred_target);
        end
    endtask

    initial begin
        rst = 1; if_valid = 0; if_pc = 0; ex_idle();
        test_reset();
        test_first_branch();
        test_saturate();
        test_alias();
        test_wrong_target();
        test_non_cf();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the EX-stage branch resolver: predicts direction and target for each fetched PC from a direct-mapped BHT/BTB.
- Consumes the resolved outcome (taken bit from branch control plus computed target) to train its tables.
- Raises a registered one-cycle flush with a redirect PC on a misprediction.
- Sits between the PC/IF stage and the EX stage of the core.

Parameters:
- IDX_BITS, 6: log2 of the number of table entries (64 entries by default).
- XLEN, 32: PC and target width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  IF stage holds a valid PC this cycle.
- if_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  predicted taken for if_pc (combinational).
- pred_target  out  XLEN  predicted next PC for if_pc (combinational).
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_cf_op  in  1  EX instruction is a conditional branch or a jump.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_taken  in  1  resolved taken bit from branch control.
- ex_target  in  XLEN  resolved target address.
- ex_pred_taken  in  1  pred_taken value carried down the pipe with this instruction.
- ex_pred_target  in  XLEN  pred_target value carried down the pipe with this instruction.
- flush  out  1  one-cycle pulse: squash IF/ID and load redirect_pc.
- redirect_pc  out  XLEN  correct next PC; valid while flush=1.
- mispredict_count  out  32  running count of mispredictions.

Behaviour:
- Reset (async, rst=1):
  - All 2^IDX_BITS counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - flush = 0, redirect_pc = 0, mispredict_count = 0.
  - Tag and target arrays need no reset.
  - Reset asserted mid-operation aborts any pending flush immediately.
- Indexing:
  - idx = pc[IDX_BITS+1:2].
  - tag = pc[XLEN-1:IDX_BITS+2].
  - pc[1:0] is ignored.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==if_pc tag.
  - pred_taken = if_valid && hit && counter[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, where +4 wraps modulo 2^XLEN.
- Update occurs at the rising edge when ex_valid && ex_cf_op && !flush:
  - Counter: ex_taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
  - If ex_taken: tag[idx]←ex_pc tag, target[idx]←ex_target, valid[idx]←1.
  - If not taken: the BTB entry is left unchanged, including when the tag differs. Aliasing is tolerated; the counter is shared.
- Mispredict:
  - mis = ex_valid && ex_cf_op && !flush && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- Flush (registered, 1-cycle latency from EX):
  - Next cycle flush = mis.
  - If mis: redirect_pc ← ex_taken ? ex_target : ex_pc+4. Otherwise redirect_pc holds its value.
  - flush is never high two consecutive cycles, because the cycle with flush=1 masks EX.
- Squash masking: while flush=1, the EX input is wrong-path. It performs no table update, cannot raise mis, and does not count.
- mispredict_count increments by 1 on every mis and saturates at 32'hFFFF_FFFF (no wrap).
- Simultaneous lookup and update to the same idx: lookup returns the pre-edge contents. The new contents are visible the cycle after the edge. There is no bypass.
- Non-control-flow EX instructions (ex_cf_op=0) never touch the tables or flush.

Test Plan:
- Reset, then if_pc=0x100 with if_valid=1 → pred_taken=0, pred_target=0x104. All idx return not-taken; mispredict_count=0.
- EX branch: ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 → next cycle flush=1 and redirect_pc=0x80; count=1.
  - Same sequence → counter[0]=2'b10, so lookup 0x100 now gives pred_taken=1, pred_target=0x80.
- Train 0x100 taken 3 times → counter saturates at 2'b11. Then 1 not-taken, with pred_taken=1 carried → flush=1, redirect_pc=0x104, counter=2'b10. Prediction stays taken.
- Mispredict at cycle N; at N+1 (flush=1) present a second mispredicting branch in EX → no flush at N+2, no table change, count increments once only.
- Aliasing: train 0x100 taken to 0x80; look up 0x200 (same idx 0 with IDX_BITS=6, different tag) → pred_taken=0, pred_target=0x204.
- Taken with wrong target: ex_pred_taken=1, ex_pred_target=0x80, ex_target=0x90 → flush, redirect_pc=0x90, BTB target updated to 0x90.
- Async reset mid-flush: assert rst while flush=1 → flush and count drop to 0 immediately, without waiting for a clock edge.
